// File: rtl/sign_extend_pkg.sv
// Shared constants for the RV32 immediate formatter: format select codes and
// a legality helper used by both the decoder and the output stage.
package sign_extend_pkg;

  localparam int INST_W = 32;
  localparam int FMT_W  = 3;

  localparam logic [FMT_W-1:0] IMM_B = 3'b000;
  localparam logic [FMT_W-1:0] IMM_I = 3'b001;
  localparam logic [FMT_W-1:0] IMM_S = 3'b010;
  localparam logic [FMT_W-1:0] IMM_U = 3'b011;
  localparam logic [FMT_W-1:0] IMM_J = 3'b100;

  // Codes above IMM_J carry no immediate format.
  function automatic logic fmt_is_legal(input logic [FMT_W-1:0] fmt);
    return (fmt <= IMM_J);
  endfunction

endpackage

// File: rtl/sign_extend_imm_decode.sv
// Combinational immediate formatter: gathers the scattered immediate bits of
// an RV32 instruction for the selected format and sign-extends to XLEN.
module imm_decode
  import sign_extend_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INST_W-1:0] instruction,
  input  logic [FMT_W-1:0]  inst_type,
  output logic [XLEN-1:0]   imm,
  output logic              illegal
);

  logic [31:0] w_imm32;
  logic        w_sign;
  logic        w_unused_opcode;

  assign w_sign = instruction[31];

  // The opcode field never participates: the format comes from inst_type alone.
  assign w_unused_opcode = ^instruction[6:0];

  always_comb begin
    w_imm32 = '0;
    case (inst_type)
      IMM_I: w_imm32 = {{20{w_sign}}, instruction[31:20]};
      IMM_S: w_imm32 = {{20{w_sign}}, instruction[31:25], instruction[11:7]};
      IMM_B: w_imm32 = {{19{w_sign}}, w_sign, instruction[7], instruction[30:25],
                        instruction[11:8], 1'b0};
      IMM_U: w_imm32 = {instruction[31:12], 12'b0};
      IMM_J: w_imm32 = {{11{w_sign}}, w_sign, instruction[19:12], instruction[20],
                        instruction[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign illegal = !fmt_is_legal(inst_type);

  // Bit 31 of the 32-bit immediate is the sign for every format, U included.
  generate
    if (XLEN > 32) begin : g_wide
      assign imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_native
      assign imm = w_imm32[XLEN-1:0];
    end
  endgenerate

endmodule

// File: rtl/sign_extend.sv
// Registered immediate extractor: one-cycle pipeline stage around imm_decode
// with valid tracking, illegal-format flag and asynchronous active-low reset.
module sign_extend
  import sign_extend_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [INST_W-1:0] instruction,
  input  logic [FMT_W-1:0]  inst_type,
  output logic [XLEN-1:0]   out,
  output logic              out_valid,
  output logic              type_err
);

  logic [XLEN-1:0] w_imm;
  logic            w_illegal;

  logic [XLEN-1:0] r_out;
  logic            r_out_valid;
  logic            r_type_err;

  imm_decode #(
    .XLEN(XLEN)
  ) u_imm_decode (
    .instruction(instruction),
    .inst_type  (inst_type),
    .imm        (w_imm),
    .illegal    (w_illegal)
  );

  // out/type_err only load on valid input so they hold through idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_type_err  <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out      <= w_illegal ? '0 : w_imm;
        r_type_err <= w_illegal;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign type_err  = r_type_err;

endmodule

// File: tb/tb_sign_extend.sv
// Directed plus randomized check of sign_extend against an arithmetic model
// of the RV32 immediate formats.
module tb_sign_extend;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instruction;
  logic [2:0]  inst_type;
  logic [31:0] out;
  logic        out_valid;
  logic        type_err;

  int n_vectors;
  int n_checks;
  int miscompares;

  logic [31:0] exp_out;
  logic        exp_err;

  sign_extend #(
    .XLEN(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .instruction(instruction),
    .inst_type  (inst_type),
    .out        (out),
    .out_valid  (out_valid),
    .type_err   (type_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Immediate value computed with integer arithmetic from the field layout.
  function automatic void model(input logic [31:0] ins, input logic [2:0] t,
                                output logic [31:0] imm, output logic err);
    int s;
    int hi;
    s   = int'(signed'(ins));
    err = 1'b0;
    case (t)
      3'd1: begin
        hi  = s >>> 20;
        imm = hi;
      end
      3'd2: begin
        hi  = s >>> 25;
        imm = (hi * 32) + ((ins >> 7) & 32'd31);
      end
      3'd0: begin
        hi  = s >>> 31;
        imm = (hi * 4096) + (((ins >> 7) & 32'd1) * 2048)
            + (((ins >> 25) & 32'd63) * 32) + (((ins >> 8) & 32'd15) * 2);
      end
      3'd3: imm = ins & 32'hFFFF_F000;
      3'd4: begin
        hi  = s >>> 31;
        imm = (hi * 1048576) + (((ins >> 12) & 32'd255) * 4096)
            + (((ins >> 20) & 32'd1) * 2048) + (((ins >> 21) & 32'd1023) * 2);
      end
      default: begin
        imm = 32'd0;
        err = 1'b1;
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] e_out,
                       input logic e_vld, input logic e_err);
    n_checks++;
    assert (out === e_out) else begin
      miscompares++;
      $error("FAIL %s out: got %08h want %08h", tag, out, e_out);
    end
    n_checks++;
    assert (out_valid === e_vld) else begin
      miscompares++;
      $error("FAIL %s out_valid: got %b want %b", tag, out_valid, e_vld);
    end
    n_checks++;
    assert (type_err === e_err) else begin
      miscompares++;
      $error("FAIL %s type_err: got %b want %b", tag, type_err, e_err);
    end
  endtask

  // Drive right after a falling edge, check at the next falling edge.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [2:0] t);
    logic [31:0] m_imm;
    logic        m_err;
    in_valid    = v;
    instruction = ins;
    inst_type   = t;
    if (v) begin
      model(ins, t, m_imm, m_err);
      exp_out = m_imm;
      exp_err = m_err;
    end
    @(negedge clk);
    n_vectors++;
    $display("txn %-8s v=%b ins=%08h t=%0d -> out=%08h vld=%b err=%b",
             tag, v, ins, t, out, out_valid, type_err);
    check(tag, exp_out, v, exp_err);
  endtask

  // Directed step that also pins the result to a literal value.
  task automatic step_lit(input string tag, input logic [31:0] ins,
                          input logic [2:0] t, input logic [31:0] lit,
                          input logic lit_err);
    step(tag, 1'b1, ins, t);
    n_checks++;
    assert (out === lit && type_err === lit_err) else begin
      miscompares++;
      $error("FAIL %s literal: got %08h/%b want %08h/%b", tag, out, type_err, lit, lit_err);
    end
  endtask

  initial begin
    n_vectors   = 0;
    n_checks    = 0;
    miscompares = 0;
    exp_out     = '0;
    exp_err     = 1'b0;

    // Reset held with valid input present: it must be discarded.
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    instruction = 32'hFFF0_0013;
    inst_type   = 3'd0;
    repeat (3) @(negedge clk);
    check("reset", 32'd0, 1'b0, 1'b0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst", 32'd0, 1'b0, 1'b0);

    step_lit("b_type", 32'hFFF0_0013, 3'd0, 32'hFFFF_F7E0, 1'b0);
    step_lit("i_type", 32'h0040_8023, 3'd1, 32'h0000_0004, 1'b0);
    step_lit("s_type", 32'hFE00_06E3, 3'd2, 32'hFFFF_FFED, 1'b0);
    step_lit("u_type", 32'h0000_1037, 3'd3, 32'h0000_1000, 1'b0);
    step_lit("j_type", 32'h0040_006F, 3'd4, 32'h0000_0004, 1'b0);
    step_lit("u_neg", 32'h8000_0037, 3'd3, 32'h8000_0000, 1'b0);
    step_lit("illegal", 32'hFFFF_FFFF, 3'd5, 32'h0000_0000, 1'b1);
    step("hold", 1'b0, 32'h1234_5678, 3'd1);
    step_lit("j_neg", 32'hFFFF_FFEF, 3'd4, 32'hFFFF_FFFE, 1'b0);
    step("hold_x", 1'b0, 32'hxxxx_xxxx, 3'bxxx);
    step_lit("ill_111", 32'h0040_8023, 3'd7, 32'h0000_0000, 1'b1);
    step_lit("err_clr", 32'hFFF0_0013, 3'd1, 32'hFFFF_FFFF, 1'b0);

    // Randomized traffic, mostly valid, all eight format codes.
    for (int i = 0; i < 60; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)));
    end

    // Asynchronous reset mid-stream, between clock edges.
    step("pre_rst", 1'b1, 32'hFFF0_0013, 3'd0);
    in_valid    = 1'b1;
    instruction = 32'hFE00_06E3;
    inst_type   = 3'd2;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'd0, 1'b0, 1'b0);
    exp_out = '0;
    exp_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("in_rst", 32'd0, 1'b0, 1'b0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_rel", 32'd0, 1'b0, 1'b0);

    // Five back-to-back transactions after release.
    step("strm0", 1'b1, 32'h0040_8023, 3'd1);
    step("strm1", 1'b1, 32'hFE00_06E3, 3'd2);
    step("strm2", 1'b1, 32'hFFF0_0013, 3'd0);
    step("strm3", 1'b1, 32'h0000_1037, 3'd3);
    step("strm4", 1'b1, 32'h0040_006F, 3'd4);
    step("drain", 1'b0, 32'h0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, miscompares);
    $finish;
  end

endmodule
